// File: rtl/paint_stroke_gen.sv
// rtl/paint_stroke_gen.sv - mouse-driven paint stroke rasterizer (Bresenham pixel writer)
//
// Purpose: turns cursor position plus button state into a stream of framebuffer
// pixel writes. While a pen button is held, each cursor move becomes a line
// segment from the previous endpoint to the new cursor position.
//
// Ports:
//   clk        - system clock, all logic on posedge
//   reset      - synchronous active-high reset
//   mx, my     - cursor position (12 bit), clamped to MAX_X/MAX_Y internally
//   btn_click  - [2]=left (pen), [1]=middle (ignored), [0]=right (eraser, color 0)
//   color_in   - pen color
//   pix_x/y    - pixel write coordinate (registered)
//   pix_color  - pixel write color (registered)
//   pix_we     - pixel write valid (registered)
//   pix_ready  - framebuffer accepts the presented pixel this cycle
//   busy       - high while a segment is being rasterized
module paint_stroke_gen #(
  parameter int MAX_X = 1023,
  parameter int MAX_Y = 767
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] mx,
  input  logic [11:0] my,
  input  logic [2:0]  btn_click,
  input  logic [7:0]  color_in,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [7:0]  pix_color,
  output logic        pix_we,
  input  logic        pix_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    LINE = 2'd2
  } state_t;

  localparam logic [11:0] MAX_X_C = 12'(MAX_X);
  localparam logic [11:0] MAX_Y_C = 12'(MAX_Y);

  state_t             state;
  logic [11:0]        cur_x, cur_y;     // pixel currently presented / about to be presented
  logic [11:0]        tgt_x, tgt_y;     // segment end, also start of the next segment
  logic               neg_x, neg_y;     // step direction: 1 = decrement
  logic [11:0]        dx_abs, dy_abs;
  logic signed [15:0] err;
  logic [7:0]         seg_color;

  // Clamped cursor and segment-start selection
  logic [11:0]        cmx, cmy;
  logic [11:0]        seg_sx, seg_sy;
  logic [11:0]        new_dx, new_dy;
  logic               new_neg_x, new_neg_y;
  logic signed [15:0] new_err;
  logic               pen_down;
  logic [7:0]         new_color;
  logic               moved;

  // Bresenham step
  logic signed [16:0] e2, dx_s, dy_s, err_ext, err_nx;
  logic               step_x, step_y;
  logic [11:0]        nx, ny;
  logic               at_target;

  always_comb begin
    cmx       = (mx > MAX_X_C) ? MAX_X_C : mx;
    cmy       = (my > MAX_Y_C) ? MAX_Y_C : my;
    pen_down  = btn_click[2] | btn_click[0];
    new_color = btn_click[0] ? 8'h00 : color_in;
    moved     = (cmx != tgt_x) || (cmy != tgt_y);

    // From IDLE the segment is a single pixel at the cursor; from HOLD it
    // continues from the previous target.
    seg_sx    = (state == HOLD) ? tgt_x : cmx;
    seg_sy    = (state == HOLD) ? tgt_y : cmy;
    new_neg_x = cmx < seg_sx;
    new_neg_y = cmy < seg_sy;
    new_dx    = new_neg_x ? (seg_sx - cmx) : (cmx - seg_sx);
    new_dy    = new_neg_y ? (seg_sy - cmy) : (cmy - seg_sy);
    new_err   = signed'({4'd0, new_dx}) - signed'({4'd0, new_dy});
  end

  always_comb begin
    err_ext = {err[15], err};
    e2      = {err, 1'b0};
    dx_s    = signed'({5'd0, dx_abs});
    dy_s    = -signed'({5'd0, dy_abs});
    step_x  = (e2 >= dy_s);
    step_y  = (e2 <= dx_s);
    err_nx  = err_ext + (step_x ? dy_s : 17'sd0) + (step_y ? dx_s : 17'sd0);
    nx      = cur_x;
    ny      = cur_y;
    if (step_x) nx = neg_x ? (cur_x - 12'd1) : (cur_x + 12'd1);
    if (step_y) ny = neg_y ? (cur_y - 12'd1) : (cur_y + 12'd1);
    at_target = (cur_x == tgt_x) && (cur_y == tgt_y);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_x     <= '0;
      cur_y     <= '0;
      tgt_x     <= '0;
      tgt_y     <= '0;
      neg_x     <= 1'b0;
      neg_y     <= 1'b0;
      dx_abs    <= '0;
      dy_abs    <= '0;
      err       <= '0;
      seg_color <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      pix_we    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          pix_we <= 1'b0;
          if (!pen_down) begin
            state <= IDLE;
          end else if (state == IDLE || moved) begin
            cur_x     <= seg_sx;
            cur_y     <= seg_sy;
            tgt_x     <= cmx;
            tgt_y     <= cmy;
            neg_x     <= new_neg_x;
            neg_y     <= new_neg_y;
            dx_abs    <= new_dx;
            dy_abs    <= new_dy;
            err       <= new_err;
            seg_color <= new_color;
            busy      <= 1'b1;
            state     <= LINE;
          end
        end

        LINE: begin
          if (!pix_we) begin
            // First LINE cycle: present the segment start.
            pix_we    <= 1'b1;
            pix_x     <= cur_x;
            pix_y     <= cur_y;
            pix_color <= seg_color;
          end else if (pix_ready) begin
            if (at_target) begin
              pix_we <= 1'b0;
              busy   <= 1'b0;
              state  <= pen_down ? HOLD : IDLE;
            end else begin
              cur_x <= nx;
              cur_y <= ny;
              err   <= err_nx[15:0];
              pix_x <= nx;
              pix_y <= ny;
            end
          end
          // pix_we & !pix_ready: everything holds
        end

        default: begin
          state  <= IDLE;
          pix_we <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paint_stroke_gen.sv
// tb/tb_paint_stroke_gen.sv - directed self-checking bench for paint_stroke_gen
module tb_paint_stroke_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] mx = '0;
  logic [11:0] my = '0;
  logic [2:0]  btn_click = '0;
  logic [7:0]  color_in = '0;
  logic [11:0] pix_x, pix_y;
  logic [7:0]  pix_color;
  logic        pix_we;
  logic        pix_ready = 1'b1;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int viol = 0;

  int wx[$], wy[$], wc[$], wk[$];
  int px[$], py[$], pk[$];

  always #5 clk = ~clk;

  paint_stroke_gen #(.MAX_X(1023), .MAX_Y(767)) dut (
    .clk(clk), .reset(reset), .mx(mx), .my(my), .btn_click(btn_click),
    .color_in(color_in), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .pix_we(pix_we), .pix_ready(pix_ready), .busy(busy)
  );

  task automatic set_in(input logic [2:0] b, input int x, input int y, input logic [7:0] c);
    @(negedge clk);
    btn_click = b;
    mx = 12'(x);
    my = 12'(y);
    color_in = c;
  endtask

  // Records presented pixels and completed writes over ncyc negedges.
  // pix_ready is low for cycles lo_s .. lo_s+lo_n-1.
  task automatic collect(input int ncyc, input int lo_s, input int lo_n);
    wx.delete(); wy.delete(); wc.delete(); wk.delete();
    px.delete(); py.delete(); pk.delete();
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      pix_ready = !(k >= lo_s && k < lo_s + lo_n);
      if (pix_we && !busy) viol++;
      if (pix_we) begin
        px.push_back(int'(pix_x)); py.push_back(int'(pix_y)); pk.push_back(k);
      end
      if (pix_we && pix_ready) begin
        wx.push_back(int'(pix_x)); wy.push_back(int'(pix_y));
        wc.push_back(int'(pix_color)); wk.push_back(k);
      end
    end
    pix_ready = 1'b1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    btn_click = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (pix_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", pix_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (pix_x !== 12'd0) begin errors++; $display("FAIL reset_x: got %0d expected 0", pix_x); end
    checks++; if (pix_y !== 12'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", pix_y); end
    checks++; if (pix_color !== 8'd0) begin errors++; $display("FAIL reset_color: got %0h expected 0", pix_color); end
  endtask

  task automatic test_single();
    go_idle();
    set_in(3'b100, 10, 20, 8'h3C);
    collect(5, 0, 0);
    checks++;
    if (wx.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d expected 1", wx.size());
    end else begin
      checks++; if (wx[0] != 10 || wy[0] != 20) begin errors++; $display("FAIL single_xy: got (%0d,%0d) expected (10,20)", wx[0], wy[0]); end
      checks++; if (wc[0] != 8'h3C) begin errors++; $display("FAIL single_color: got %0h expected 3c", wc[0]); end
      checks++; if (wk[0] != 1) begin errors++; $display("FAIL single_latency: got cycle %0d expected 1", wk[0]); end
    end
    checks++; if (pix_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_hold: got we=%0b busy=%0b expected 0/0", pix_we, busy); end
  endtask

  task automatic test_line();
    int ex[5] = '{10, 11, 12, 13, 14};
    int ey[5] = '{20, 21, 21, 22, 22};
    set_in(3'b100, 14, 22, 8'h3C);
    collect(10, 0, 0);
    checks++;
    if (wx.size() != 5) begin
      errors++; $display("FAIL line_count: got %0d expected 5", wx.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wx[i] != ex[i] || wy[i] != ey[i] || wk[i] != i + 1) begin
          errors++;
          $display("FAIL line_px%0d: got (%0d,%0d)@%0d expected (%0d,%0d)@%0d", i, wx[i], wy[i], wk[i], ex[i], ey[i], i + 1);
        end
      end
    end
    checks++; if (pix_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL line_end: got we=%0b busy=%0b expected 0/0", pix_we, busy); end
  endtask

  task automatic test_stall();
    int ek[5] = '{1, 5, 6, 7, 8};
    int held;
    go_idle();
    set_in(3'b100, 10, 20, 8'h3C);
    collect(4, 0, 0);
    set_in(3'b100, 14, 22, 8'h3C);
    collect(12, 2, 3);
    checks++;
    if (wx.size() != 5) begin
      errors++; $display("FAIL stall_count: got %0d expected 5", wx.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wk[i] != ek[i]) begin errors++; $display("FAIL stall_time%0d: got cycle %0d expected %0d", i, wk[i], ek[i]); end
      end
    end
    held = 0;
    for (int i = 0; i < pk.size(); i++)
      if (pk[i] >= 2 && pk[i] <= 5 && px[i] == 11 && py[i] == 21) held++;
    checks++; if (held != 4) begin errors++; $display("FAIL stall_hold: got %0d cycles expected 4", held); end
  endtask

  task automatic test_right();
    int ey[4] = '{5, 4, 3, 2};
    go_idle();
    set_in(3'b001, 5, 5, 8'hAA);
    collect(4, 0, 0);
    set_in(3'b001, 5, 2, 8'hAA);
    collect(9, 0, 0);
    checks++;
    if (wx.size() != 4) begin
      errors++; $display("FAIL right_count: got %0d expected 4", wx.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wx[i] != 5 || wy[i] != ey[i] || wc[i] != 0) begin
          errors++; $display("FAIL right_px%0d: got (%0d,%0d,%0h) expected (5,%0d,0)", i, wx[i], wy[i], wc[i], ey[i]);
        end
      end
    end
  endtask

  task automatic test_clamp();
    go_idle();
    set_in(3'b100, 2000, 900, 8'h11);
    collect(5, 0, 0);
    checks++;
    if (wx.size() != 1) begin
      errors++; $display("FAIL clamp_count: got %0d expected 1", wx.size());
    end else begin
      checks++; if (wx[0] != 1023 || wy[0] != 767) begin errors++; $display("FAIL clamp_xy: got (%0d,%0d) expected (1023,767)", wx[0], wy[0]); end
    end
  endtask

  task automatic test_reset_mid();
    go_idle();
    set_in(3'b100, 0, 0, 8'h22);
    collect(4, 0, 0);
    set_in(3'b100, 9, 0, 8'h22);
    repeat (3) @(negedge clk);
    checks++; if (pix_we !== 1'b1 || pix_x !== 12'd1) begin errors++; $display("FAIL rmid_second: got we=%0b x=%0d expected 1/1", pix_we, pix_x); end
    reset = 1'b1;
    btn_click = 3'b000;
    @(negedge clk);
    checks++; if (pix_we !== 1'b0) begin errors++; $display("FAIL rmid_we: got %0b expected 0", pix_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b expected 0", busy); end
    reset = 1'b0;
    collect(8, 0, 0);
    checks++; if (wx.size() != 0) begin errors++; $display("FAIL rmid_quiet: got %0d writes expected 0", wx.size()); end
    set_in(3'b100, 3, 3, 8'h22);
    collect(4, 0, 0);
    checks++;
    if (wx.size() != 1) begin
      errors++; $display("FAIL rmid_repress: got %0d writes expected 1", wx.size());
    end else begin
      checks++; if (wx[0] != 3 || wy[0] != 3) begin errors++; $display("FAIL rmid_repress_xy: got (%0d,%0d) expected (3,3)", wx[0], wy[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_line();
    test_stall();
    test_right();
    test_clamp();
    test_reset_mid();
    checks++; if (viol != 0) begin errors++; $display("FAIL we_outside_busy: got %0d cycles expected 0", viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/paint_stroke_gen.md
PAINT_STROKE_GEN -- requirements
Module: paint_stroke_gen

Interface
REQ-001 SHALL have parameter MAX_X, default 1023, meaning largest legal pixel X.
REQ-002 SHALL have parameter MAX_Y, default 767, meaning largest legal pixel Y.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mx  input  12  current cursor X, from the mouse position tracker.
REQ-006 SHALL have port my  input  12  current cursor Y, from the mouse position tracker.
REQ-007 SHALL have port btn_click  input  3  buttons, [2]=left, [1]=middle (ignored), [0]=right.
REQ-008 SHALL have port color_in  input  8  pen color.
REQ-009 SHALL have port pix_x  output  12  pixel write X.
REQ-010 SHALL have port pix_y  output  12  pixel write Y.
REQ-011 SHALL have port pix_color  output  8  pixel write color.
REQ-012 SHALL have port pix_we  output  1  pixel write request (valid).
REQ-013 SHALL have port pix_ready  input  1  framebuffer accepts pixel this cycle.
REQ-014 SHALL have port busy  output  1  high while a segment is being rasterized.

Function
REQ-015 SHALL clamp sampled mx/my to MAX_X/MAX_Y before any use.
REQ-016 SHALL define pen_down = btn_click[2] | btn_click[0]; segment color = 0 if btn_click[0] else color_in, latched at segment start.
REQ-017 SHALL implement states IDLE (pen up), HOLD (pen down, waiting for motion), LINE (rasterizing).
REQ-018 IDLE: on pen_down, SHALL latch start = target = clamped (mx,my), latch color, enter LINE (single-pixel segment).
REQ-019 HOLD: if pen_down low -> IDLE; else if clamped (mx,my) != last target -> start = last target, target = clamped (mx,my), latch color, enter LINE; else stay.
REQ-020 LINE SHALL rasterize start->target by Bresenham: dx=|tx-sx|, dy=-|ty-sy|, step signs from comparison, err=dx+dy initially; per step e2=2*err; if e2>=dy {err+=dy; x+=stepx}; if e2<=dx {err+=dx; y+=stepy}.
REQ-021 err/e2 SHALL be signed, at least 14 bits; no overflow for any endpoints within 0..MAX.
REQ-022 Each segment SHALL emit start and target inclusive: exactly max(dx,|dy|)+1 writes.
REQ-023 pix_we, pix_x, pix_y, pix_color SHALL be registered; first write asserts the cycle after the state entering LINE is registered (2 cycles after the triggering input sample).
REQ-024 A write completes on a cycle with pix_we & pix_ready; while pix_we & !pix_ready, pix_x/pix_y/pix_color SHALL hold stable.
REQ-025 With pix_ready held high, SHALL sustain one write per cycle.
REQ-026 After the write of target completes, SHALL go to HOLD (pix_we low next cycle) if pen_down, else IDLE.
REQ-027 Cursor motion and button release during LINE SHALL NOT abort or alter the current segment; the next segment starts from its target.
REQ-028 busy SHALL be high exactly while in LINE.
REQ-029 pix_we SHALL never be high outside LINE.

Reset
REQ-030 On reset: state IDLE, pix_we=0, busy=0, pix_x=0, pix_y=0, pix_color=0, internal endpoints and err=0.
REQ-031 Reset during LINE SHALL drop pix_we and busy the next cycle, no further writes, regardless of pix_ready.

Verification
REQ-032 Left press, cursor (10,20), color_in=8'h3C, pix_ready=1, no motion -> exactly one write (10,20,3C), then HOLD, pix_we low.
REQ-033 Held at (10,20), cursor moves to (14,22) -> writes (10,20),(11,21),(12,21),(13,22),(14,22) on consecutive cycles, then idle.
REQ-034 During REQ-033, pix_ready low 3 cycles on second write -> (11,21) held 4 cycles, sequence otherwise unchanged.
REQ-035 Right button at (5,5), move to (5,2) -> writes (5,5),(5,4),(5,3),(5,2) with color 0.
REQ-036 mx=2000, my=900 with left press -> single write at (1023,767).
REQ-037 Reset asserted on 2nd write of a 10-pixel segment -> pix_we=0 and busy=0 next cycle; no writes until a new press.
